// File: rtl/datapath_p2.sv
// datapath_p2 -- 32-bit single-bus CPU datapath (phase 2).
//
// Holds R0..R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, InPort, OutPort and
// the CON branch-condition flop. All transfers are driven by one-hot control
// strobes from an external control unit; memory sits outside and returns
// read data on Mdatain.
//
// Ports:
//   outp                 OutPort register contents
//   PCout..InPortout     bus source selects (fixed priority if several set)
//   MARin..OutPortin     register load enables
//   IncPC                ALU computes bus+1 regardless of opcode
//   Read                 MDR input mux takes Mdatain instead of the bus
//   Write                memory write strobe, no internal effect
//   Gra/Grb/Grc          select IR Ra/Rb/Rc field for register addressing
//   Rin/Rout/BAout       write / read / base-address read of selected reg
//   Cout                 sign-extended IR constant onto the bus
//   CONIn                load CON flop from the bus condition
//   Strobe               load InPort from Mdatain
//   Clock, Clear         rising-edge clock, async active-low clear
//   Mdatain              memory / input-device data
//   CON_out              CON flop state

// One general-purpose register: async clear, load on enable.
module datapath_p2_reg #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)    o_q <= '0;
    else if (i_en) o_q <= i_d;
  end
endmodule

module datapath_p2 #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  output logic [WIDTH-1:0] outp,
  input  logic             PCout,
  input  logic             Zhiout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             InPortout,
  input  logic             MARin,
  input  logic             Zin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             OutPortin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             Write,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin,
  input  logic             Rout,
  input  logic             BAout,
  input  logic             Cout,
  input  logic             CONIn,
  input  logic             Strobe,
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Mdatain,
  output logic             CON_out
);
  localparam int SELW = $clog2(NREGS);

  typedef enum logic [4:0] {
    OP_SUB = 5'b00100,
    OP_AND = 5'b00101,
    OP_OR  = 5'b00110,
    OP_SHR = 5'b00111,
    OP_SHL = 5'b01001,
    OP_NEG = 5'b10000,
    OP_NOT = 5'b10001
  } op_e;

  logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_inport, r_outport;
  logic [2*WIDTH-1:0] r_z;
  logic               r_con;

  logic [WIDTH-1:0]              w_bus, w_alu, w_cext, w_rdata;
  logic [4:0]                    w_opcode;
  logic [SELW-1:0]               w_ra, w_rb, w_rc, w_field;
  logic [1:0]                    w_c2;
  logic [NREGS-1:0]              w_rsel;
  logic [NREGS-1:0][WIDTH-1:0]   w_rf;
  logic                          w_cond;

  // ---- IR field extraction ----
  assign w_opcode = r_ir[31:27];
  assign w_ra     = r_ir[23 +: SELW];
  assign w_rb     = r_ir[19 +: SELW];
  assign w_rc     = r_ir[15 +: SELW];
  assign w_c2     = r_ir[20:19];
  assign w_cext   = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};

  // ---- select and encode: OR of the gated fields, decoded one-hot ----
  assign w_field = ({SELW{Gra}} & w_ra) | ({SELW{Grb}} & w_rb) | ({SELW{Grc}} & w_rc);

  always_comb begin
    w_rsel          = '0;
    w_rsel[w_field] = 1'b1;
  end

  // ---- general register file ----
  for (genvar g = 0; g < NREGS; g++) begin : g_rf
    datapath_p2_reg #(.WIDTH(WIDTH)) u_r (
      .Clock (Clock),
      .Clear (Clear),
      .i_en  (Rin & w_rsel[g]),
      .i_d   (w_bus),
      .o_q   (w_rf[g])
    );
  end

  // BAout treats R0 as a hard zero so it can serve as "no base register".
  assign w_rdata = (BAout && (w_field == '0)) ? '0 : w_rf[w_field];

  // ---- bus: priority mux, zero when idle ----
  always_comb begin
    w_bus = '0;
    if (Rout || BAout) w_bus = w_rdata;
    else if (HIout)    w_bus = r_hi;
    else if (LOout)    w_bus = r_lo;
    else if (Zhiout)   w_bus = r_z[2*WIDTH-1:WIDTH];
    else if (Zlowout)  w_bus = r_z[WIDTH-1:0];
    else if (PCout)    w_bus = r_pc;
    else if (MDRout)   w_bus = r_mdr;
    else if (InPortout) w_bus = r_inport;
    else if (Cout)     w_bus = w_cext;
  end

  // ---- ALU: A = Y, B = bus; anything undecoded (ADD, addi, ld, st, br) adds ----
  always_comb begin
    w_alu = r_y + w_bus;
    if (IncPC) begin
      w_alu = w_bus + WIDTH'(1);
    end else begin
      case (w_opcode)
        OP_SUB:  w_alu = r_y - w_bus;
        OP_AND:  w_alu = r_y & w_bus;
        OP_OR:   w_alu = r_y | w_bus;
        OP_SHR:  w_alu = r_y >> w_bus[4:0];
        OP_SHL:  w_alu = r_y << w_bus[4:0];
        OP_NEG:  w_alu = '0 - w_bus;
        OP_NOT:  w_alu = ~w_bus;
        default: w_alu = r_y + w_bus;
      endcase
    end
  end

  // ---- branch condition on the current bus value ----
  always_comb begin
    w_cond = 1'b0;
    case (w_c2)
      2'b00: w_cond = (w_bus == '0);
      2'b01: w_cond = (w_bus != '0);
      2'b10: w_cond = ~w_bus[WIDTH-1];
      2'b11: w_cond = w_bus[WIDTH-1];
      default: w_cond = 1'b0;
    endcase
  end

  // ---- special registers ----
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_inport  <= '0;
      r_outport <= '0;
      r_con     <= 1'b0;
    end else begin
      if (PCin)      r_pc      <= w_bus;
      if (IRin)      r_ir      <= w_bus;
      if (MARin)     r_mar     <= w_bus;
      if (MDRin)     r_mdr     <= Read ? Mdatain : w_bus;
      if (Yin)       r_y       <= w_bus;
      if (Zin)       r_z       <= {{WIDTH{1'b0}}, w_alu};
      if (HIin)      r_hi      <= w_bus;
      if (LOin)      r_lo      <= w_bus;
      if (Strobe)    r_inport  <= Mdatain;
      if (OutPortin) r_outport <= w_bus;
      if (CONIn)     r_con     <= w_cond;
    end
  end

  assign outp    = r_outport;
  assign CON_out = r_con;

  // MAR feeds the external memory address path only; Write is consumed outside.
  logic w_unused;
  assign w_unused = ^{Write, r_mar};

endmodule

// File: tb/tb_datapath_p2.sv
`timescale 1ns/1ps
module tb_datapath_p2;
  logic [31:0] outp, Mdatain;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic Clock, Clear, CON_out;

  int n_chk = 0, n_err = 0;
  logic [31:0] m_r [16];

  datapath_p2 dut (
    .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain),
    .CON_out(CON_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic idle();
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    Mdatain = '0;
  endtask

  task automatic step();
    @(posedge Clock); #1; idle();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Latch whatever sources the caller selected into OutPort so outp shows the bus.
  task automatic obs();
    OutPortin = 1'b1; step();
  endtask

  task automatic do_reset();
    Clear = 1'b0; idle(); step(); step(); Clear = 1'b1; #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1; step();
  endtask

  task automatic ir_load(input logic [31:0] v);
    mdr_load(v); MDRout = 1'b1; IRin = 1'b1; step();
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
    ir_load({5'b0, idx, 23'b0});
    mdr_load(v); MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
    m_r[idx] = v;
  endtask

  task automatic set_y(input logic [31:0] v);
    mdr_load(v); MDRout = 1'b1; Yin = 1'b1; step();
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic inc,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if (inc) return b + 32'd1;
    case (op)
      5'd4:  return a - b;
      5'd5:  return a & b;
      5'd6:  return a | b;
      5'd7:  return a >> sh;
      5'd9:  return a << sh;
      5'd16: return 32'd0 - b;
      5'd17: return ~b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_con(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'd0: return v == 0;
      2'd1: return v != 0;
      2'd2: return v < 32'h8000_0000;
      default: return v >= 32'h8000_0000;
    endcase
  endfunction

  task automatic run_alu(input logic [4:0] op, input logic inc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string nm);
    ir_load({op, 27'b0});
    set_y(a);
    mdr_load(b);
    MDRout = 1'b1; Zin = 1'b1; IncPC = inc; step();
    Zlowout = 1'b1; obs();
    chk(nm, outp, exp);
  endtask

  alu_vec_t vt [14];

  initial begin
    vt[0]  = '{5'b00011, 1'b0, 32'd7,          32'd3,          32'd10};
    vt[1]  = '{5'b00100, 1'b0, 32'd7,          32'd3,          32'd4};
    vt[2]  = '{5'b10000, 1'b0, 32'd7,          32'd3,          32'hFFFF_FFFD};
    vt[3]  = '{5'b01001, 1'b0, 32'd7,          32'd3,          32'd56};
    vt[4]  = '{5'b00101, 1'b0, 32'hF0F0_FFFF,  32'h0FF0_00FF,  32'h00F0_00FF};
    vt[5]  = '{5'b00110, 1'b0, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    vt[6]  = '{5'b00111, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000};
    vt[7]  = '{5'b00111, 1'b0, 32'h0000_0040,  32'h0000_0025,  32'd2};
    vt[8]  = '{5'b10001, 1'b0, 32'd123,        32'h0F0F_0000,  32'hF0F0_FFFF};
    vt[9]  = '{5'b00011, 1'b0, 32'hFFFF_FFFF,  32'd2,          32'd1};
    vt[10] = '{5'b00100, 1'b0, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vt[11] = '{5'b00100, 1'b1, 32'd100,        32'd41,         32'd42};
    vt[12] = '{5'b01010, 1'b0, 32'd5,          32'd6,          32'd11};
    vt[13] = '{5'b01001, 1'b0, 32'd1,          32'd31,         32'h8000_0000};

    Clear = 1'b0; idle();
    #2;
    chk("reset_outp", outp, 32'd0);
    chk("reset_con", {31'b0, CON_out}, 32'd0);
    step(); Clear = 1'b1; #1;

    // ---- reset state ----
    PCout = 1'b1; obs(); chk("reset_pc", outp, 32'd0);
    Cout = 1'b1;  obs(); chk("reset_ir_c", outp, 32'd0);
    Zlowout = 1'b1; obs(); chk("reset_zlo", outp, 32'd0);
    HIout = 1'b1; obs(); chk("reset_hi", outp, 32'd0);
    InPortout = 1'b1; obs(); chk("reset_inport", outp, 32'd0);
    MDRout = 1'b1; obs(); chk("reset_mdr", outp, 32'd0);
    Zin = 1'b1; step(); Zlowout = 1'b1; obs(); chk("reset_y", outp, 32'd0);
    for (int i = 0; i < 16; i++) begin
      ir_load(32'(i) << 23);
      Gra = 1'b1; Rout = 1'b1; obs();
      chk($sformatf("reset_r%0d", i), outp, 32'd0);
    end

    // ---- fetch ----
    do_reset();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; step();
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h9100_0023; step();
    MDRout = 1'b1; IRin = 1'b1; step();
    PCout = 1'b1; obs(); chk("fetch_pc", outp, 32'd1);
    Cout = 1'b1;  obs(); chk("fetch_ir_c", outp, 32'd35);
    MDRout = 1'b1; obs(); chk("fetch_mdr", outp, 32'h9100_0023);

    // ---- brzr R2,35 taken ----
    Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; step();
    chk("brzr_taken", {31'b0, CON_out}, 32'd1);
    PCout = 1'b1; Yin = 1'b1; step();
    Cout = 1'b1; Zin = 1'b1; step();
    Zlowout = 1'b1; obs(); chk("br_target_z", outp, 32'd36);
    Zlowout = 1'b1; PCin = 1'b1; step();
    PCout = 1'b1; obs(); chk("br_pc", outp, 32'd36);

    // ---- brzr not taken, brmi taken ----
    set_reg(4'd2, 32'd5);
    ir_load(32'h9100_0023);
    Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; step();
    chk("brzr_not_taken", {31'b0, CON_out}, 32'd0);
    set_reg(4'd2, 32'h8000_0000);
    ir_load(32'h9118_0023);
    Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; step();
    chk("brmi_taken", {31'b0, CON_out}, 32'd1);
    CONIn = 1'b1; step();
    chk("con_idle_bus_brmi", {31'b0, CON_out}, 32'd0);

    // ---- ALU table ----
    foreach (vt[i]) run_alu(vt[i].op, vt[i].inc, vt[i].a, vt[i].b, vt[i].exp,
                            $sformatf("alu_vec%0d", i));
    Zhiout = 1'b1; obs(); chk("zhi_zero", outp, 32'd0);

    // ---- ports, BAout, bus priority ----
    Strobe = 1'b1; Mdatain = 32'hA5; step();
    InPortout = 1'b1; obs(); chk("inport", outp, 32'hA5);
    mdr_load(32'h1234); MDRout = 1'b1; obs(); chk("outport", outp, 32'h1234);
    obs(); chk("bus_idle_zero", outp, 32'd0);
    set_reg(4'd0, 32'd9);
    Gra = 1'b1; Rout = 1'b1; obs(); chk("r0_rout", outp, 32'd9);
    Gra = 1'b1; BAout = 1'b1; obs(); chk("r0_baout", outp, 32'd0);
    mdr_load(32'd77); MDRout = 1'b1; HIin = 1'b1; step();
    mdr_load(32'd88); MDRout = 1'b1; LOin = 1'b1; step();
    HIout = 1'b1; LOout = 1'b1; obs(); chk("prio_hi_lo", outp, 32'd77);
    MDRout = 1'b1; LOout = 1'b1; obs(); chk("prio_lo_mdr", outp, 32'd88);
    Gra = 1'b1; Rout = 1'b1; HIout = 1'b1; obs(); chk("prio_r_hi", outp, 32'd9);

    // ---- Clear mid-sequence beats pending loads ----
    mdr_load(32'hCAFE);
    Mdatain = 32'hDEAD; Read = 1'b1; MDRin = 1'b1; MDRout = 1'b1; PCin = 1'b1;
    #2; Clear = 1'b0; #1;
    chk("midclr_outp", outp, 32'd0);
    @(posedge Clock); #1; idle(); Clear = 1'b1;
    MDRout = 1'b1; obs(); chk("midclr_mdr", outp, 32'd0);
    PCout = 1'b1; obs(); chk("midclr_pc", outp, 32'd0);

    // ---- random register file scoreboard ----
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
    for (int i = 0; i < 16; i++) begin
      int f;
      logic [31:0] irv;
      f = $urandom_range(0, 2);
      irv = (f == 0) ? (32'(i) << 23) : (f == 1) ? (32'(i) << 19) : (32'(i) << 15);
      ir_load(irv);
      Gra = (f == 0); Grb = (f == 1); Grc = (f == 2); Rout = 1'b1; obs();
      chk($sformatf("rf_r%0d_f%0d", i, f), outp, m_r[i]);
      Gra = (f == 0); Grb = (f == 1); Grc = (f == 2); BAout = 1'b1; obs();
      chk($sformatf("rf_ba_r%0d", i), outp, (i == 0) ? 32'd0 : m_r[i]);
    end

    // ---- random ALU ----
    for (int k = 0; k < 60; k++) begin
      logic [4:0]  op;
      logic        inc;
      logic [31:0] a, b;
      logic [4:0]  ops [8];
      ops = '{5'd0, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd16, 5'd17};
      op  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
      inc = ($urandom_range(0, 7) == 0);
      a = $urandom; b = $urandom;
      run_alu(op, inc, a, b, ref_alu(op, inc, a, b), $sformatf("alu_rnd%0d_op%0d", k, op));
    end

    // ---- random branch conditions ----
    for (int k = 0; k < 30; k++) begin
      logic [3:0]  idx;
      logic [1:0]  c2;
      logic [31:0] v;
      idx = 4'($urandom_range(1, 15));
      c2  = 2'($urandom);
      case ($urandom_range(0, 2))
        0: v = 32'd0;
        1: v = $urandom | 32'h8000_0000;
        default: v = $urandom & 32'h7FFF_FFFF;
      endcase
      set_reg(idx, v);
      ir_load({5'b10010, idx, 2'b00, c2, 19'd0});
      Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; step();
      chk($sformatf("con_rnd%0d_c2_%0d", k, c2), {31'b0, CON_out}, {31'b0, ref_con(c2, v)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/datapath_p2.md
Name:
datapath_p2

Overview:
32-bit single-bus CPU datapath for phase 2 of the processor design. It contains:
- general registers R0–R15, PC, IR, MAR, MDR, Y, a 64-bit Z, HI/LO, and In/Out port registers,
- a select-and-encode register-addressing unit,
- an ALU,
- a branch-condition (CON) flip-flop.

All register transfers are driven by externally supplied one-hot control strobes from a control unit or bench. Memory is external: read data arrives on Mdatain.

Parameters:
- WIDTH, 32, datapath and register width.
- NREGS, 16, number of general registers (4-bit field encoding).

Ports:
Clock and reset:
- Clock  in  1  single system clock; all registers update on the rising edge.
- Clear  in  1  asynchronous, active-low reset.

Bus source selects:
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout  in  1 each  drive PC / Z[63:32] / Z[31:0] / MDR / HI / LO / InPort onto the bus.

Register load enables:
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin  in  1 each  load the named register.

Other controls:
- IncPC  in  1  ALU computes bus+1.
- Read  in  1  MDR input mux selects Mdatain.
- Write  in  1  memory-write strobe; no internal effect.
- Gra, Grb, Grc  in  1 each  select the IR Ra / Rb / Rc field.
- Rin, Rout, BAout  in  1 each  write, read, and base-address read of the selected register.
- Cout  in  1  drive the sign-extended IR constant onto the bus.
- CONIn  in  1  load the CON flip-flop.
- Strobe  in  1  load the InPort register from Mdatain.

Data:
- Mdatain  in  32  memory/input data.
- outp  out  32  OutPort register contents.
- CON_out  out  1  CON flip-flop state.

Positional order:
outp, PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe, Clock, Clear, Mdatain, CON_out.

Behaviour:

Reset:
- Clear=0 asynchronously zeroes every register, including PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort, R0–R15 and CON.
- Consequently outp=0 and CON_out=0 during reset.

Bus:
- The bus is a combinational mux.
- Out-strobes are expected one-hot. If several are asserted, fixed priority applies: Rout/BAout, HIout, LOout, Zhiout, Zlowout, PCout, MDRout, InPortout, Cout.
- With no source selected, the bus is 0.

IR fields:
- opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15], C2 = IR[22:19].
- C = IR[18:0] sign-extended to 32 bits.

Select/encode:
- Field = (Gra?Ra)|(Grb?Rb)|(Grc?Rc), OR-combined.
- The field is decoded to a one-hot register select.
- Rin writes the bus into the selected register on the clock edge.
- Rout drives the selected register onto the bus.
- BAout does the same as Rout, except that R0 reads as 0.

MDR:
- On MDRin, MDR <= (Read ? Mdatain : bus).

Other register loads:
- MAR, PC, IR, Y, HI, LO and OutPort load the bus on their respective in-strobe.
- InPort loads Mdatain when Strobe=1.

ALU (combinational; A=Y, B=bus; Z<=result on Zin):
- IncPC=1: result = {32'b0, B+1}, overriding the opcode.
- Otherwise decode by opcode:
  - 00100 SUB: A−B.
  - 00101 AND, 00110 OR.
  - 00111 SHR, logical, by B[4:0].
  - 01001 SHL, by B[4:0].
  - 10000 NEG: −B.
  - 10001 NOT: ~B.
  - All other opcodes (ADD, addi, ld, st, branches): A+B.
- Z[63:32] is always 0. Overflow and carry wrap mod 2^32.

CON flip-flop:
- On CONIn, CON <= condition evaluated on the current bus value, selected by C2[1:0]:
  - 00 brzr: bus==0.
  - 01 brnz: bus!=0.
  - 10 brpl: bus[31]==0.
  - 11 brmi: bus[31]==1.
- PCin is not gated by CON internally; the control unit gates it using CON_out.

Timing and boundaries:
- Every register holds its value unless enabled. There is no multi-cycle latency: a strobe asserted before a clock edge takes effect at that edge.
- R0 is writable; it reads as 0 only under BAout.
- Clear asserted mid-sequence overrides any pending load.

Test Plan:
1. Reset: Clear=0, then release → PC=0, IR=0, outp=0, CON_out=0, every register read via Rout returns 0.
2. Fetch: PCout+MARin+IncPC+Zin; next cycle Zlowout+PCin+Read+MDRin with Mdatain=0x91000023; next cycle MDRout+IRin → PC=1, MAR=0, IR=0x91000023.
3. brzr R2,35 taken: with R2=0, Gra+Rout+CONIn → CON_out=1; PCout+Yin; Cout+Zin → Z low=36; Zlowout+PCin → PC=36.
4. brzr not taken: preload R2=5 via Rin, repeat scenario 3 → CON_out=0. brmi with R2=0x80000000 (C2=0011) → CON_out=1.
5. ALU: Y=7, bus=3 under opcode ADD → Z=10; under SUB → 4; under NEG → 0xFFFFFFFD; under SHL → 56.
6. Ports: Strobe with Mdatain=0xA5 → InPortout shows 0xA5 on the bus; OutPortin with bus=0x1234 → outp=0x1234. BAout with Ra=0 and R0=9 → bus=0.
